// File: rtl/nn_fixed_pkg.sv
// ============================================================================
// Module : nn_fixed_pkg
// Brief  : Q16.16 fixed-point constants and the accumulator state enumeration.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nn_fixed_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;

    localparam logic [DATA_W-1:0] Q_ONE = 32'h0001_0000;
    localparam logic [DATA_W-1:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] Q_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/neuron_accumulator_sat_clamp.sv
// ============================================================================
// Module : sat_clamp
// Brief  : Combinational signed saturation from IN_W to OUT_W bits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_clamp #(
    parameter int IN_W  = 42,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  i_value,
    output logic signed [OUT_W-1:0] o_value,
    output logic                    o_overflow
);

    logic                   w_sign;
    logic [IN_W-OUT_W:0]    w_upper;

    // The value fits only if every bit from the output MSB upward is a copy of the sign.
    assign w_sign     = i_value[IN_W-1];
    assign w_upper    = i_value[IN_W-1:OUT_W-1];
    assign o_overflow = !((&w_upper) || !(|w_upper));

    always_comb begin
        o_value = i_value[OUT_W-1:0];
        if (o_overflow) begin
            o_value = w_sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/neuron_accumulator.sv
// ============================================================================
// Module : neuron_accumulator
// Brief  : Biased, saturating Q16.16 dot-product accumulator with valid/ready
//          on both sides. Define NEURON_ACC_RELU_EN to rectify the result.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module neuron_accumulator
    import nn_fixed_pkg::*;
#(
    parameter int DATA_W = nn_fixed_pkg::DATA_W,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bias,
    input  logic [DATA_W-1:0] in_product,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int ACC_W = DATA_W + CNT_W;

    acc_state_t               r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_ovl;
    logic                     r_in_ready;
    logic [DATA_W-1:0]        r_out_result;
    logic [CNT_W-1:0]         r_out_count;
    logic                     r_out_sat;
    logic                     r_out_valid;

    logic                     w_fire;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic [CNT_W-1:0]         w_cnt_next;
    logic                     w_ovl_next;
    logic                     w_cnt_max;
    logic signed [DATA_W-1:0] w_clamped;
    logic                     w_clamp_ovf;
    logic [DATA_W-1:0]        w_result;

    assign w_fire     = in_valid && r_in_ready;
    assign w_bias_ext = {{CNT_W{bias[DATA_W-1]}}, bias};
    assign w_prod_ext = {{CNT_W{in_product[DATA_W-1]}}, in_product};
    assign w_cnt_max  = (r_cnt == {CNT_W{1'b1}});

    // The first beat of a vector seeds from bias instead of the stale accumulator.
    always_comb begin
        w_acc_next = r_acc + w_prod_ext;
        w_cnt_next = w_cnt_max ? r_cnt : r_cnt + 1'b1;
        w_ovl_next = r_ovl || w_cnt_max;
        if (r_state == IDLE) begin
            w_acc_next = w_bias_ext + w_prod_ext;
            w_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
            w_ovl_next = 1'b0;
        end
    end

    sat_clamp #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_sat_clamp (
        .i_value    (w_acc_next),
        .o_value    (w_clamped),
        .o_overflow (w_clamp_ovf)
    );

`ifdef NEURON_ACC_RELU_EN
    assign w_result = w_clamped[DATA_W-1] ? {DATA_W{1'b0}} : w_clamped;
`else
    assign w_result = w_clamped;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovl        <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_result <= '0;
            r_out_count  <= '0;
            r_out_sat    <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_fire) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        r_ovl <= w_ovl_next;
                        if (in_last) begin
                            r_state      <= HOLD;
                            r_in_ready   <= 1'b0;
                            r_out_result <= w_result;
                            r_out_count  <= w_cnt_next;
                            r_out_sat    <= w_clamp_ovf || w_ovl_next;
                            r_out_valid  <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_result = r_out_result;
    assign out_count  = r_out_count;
    assign out_sat    = r_out_sat;
    assign out_valid  = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_neuron_accumulator.sv
// ============================================================================
// Module : tb_neuron_accumulator
// Brief  : Self-checking bench for neuron_accumulator against a Q16.16
//          arithmetic reference model (honours NEURON_ACC_RELU_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_neuron_accumulator;

    localparam int DW = 32;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] bias = '0;
    logic [DW-1:0] in_product = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_result;
    logic [CW-1:0] out_count;
    logic          out_sat;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] vq[$];
    logic [DW-1:0] e_res;
    logic [CW-1:0] e_cnt;
    logic          e_sat;

    neuron_accumulator #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bias       (bias),
        .in_product (in_product),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_result (out_result),
        .out_count  (out_count),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact sum in wide integers, then Q16.16 clamp and optional ReLU.
    task automatic model(input logic [DW-1:0] b);
        longint sum;
        longint maxv = 64'sd2147483647;
        longint minv = -64'sd2147483648;
        bit     clamp;
        sum = longint'($signed(b));
        foreach (vq[i]) sum += longint'($signed(vq[i]));
        clamp = (sum > maxv) || (sum < minv);
        if (sum > maxv) sum = maxv;
        if (sum < minv) sum = minv;
`ifdef NEURON_ACC_RELU_EN
        if (sum < 0) sum = 0;
`endif
        e_res = sum[DW-1:0];
        e_cnt = (vq.size() > 1023) ? 10'd1023 : CW'(vq.size());
        e_sat = clamp || (vq.size() > 1023);
    endtask

    task automatic send_beat(input logic [DW-1:0] b, input logic [DW-1:0] p, input logic last);
        int guard = 0;
        in_valid   = 1'b1;
        bias       = b;
        in_product = p;
        in_last    = last;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
    endtask

    task automatic send_vector(input logic [DW-1:0] b, input bit bubbles);
        for (int i = 0; i < vq.size(); i++) begin
            if (bubbles && $urandom_range(0, 1) == 1) begin
                in_valid   = 1'b0;
                in_last    = 1'($urandom);
                in_product = $urandom;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            send_beat((i == 0) ? b : $urandom, vq[i], i == vq.size() - 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [DW-1:0] b);
        model(b);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_result"}, {32'd0, out_result}, {32'd0, e_res});
        chk({tag, "_count"}, {54'd0, out_count}, {54'd0, e_cnt});
        chk({tag, "_sat"}, {63'd0, out_sat}, {63'd0, e_sat});
        if (out_ready) begin
            @(negedge clk);
            chk({tag, "_pulse"}, {63'd0, out_valid}, 64'd0);
        end
    endtask

    function automatic logic [DW-1:0] rand_prod();
        logic [DW-1:0] r = $urandom;
        if ($urandom_range(0, 3) == 0) return r;
        return {{14{r[31]}}, r[17:0]};
    endfunction

    initial begin
        logic [DW-1:0] held;
        logic [DW-1:0] b2;
        logic [DW-1:0] p2;

        // Reset state
        #1;
        chk("rst_result", {32'd0, out_result}, 64'd0);
        chk("rst_count", {54'd0, out_count}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_before_edge", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("ready_after_edge", {63'd0, in_ready}, 64'd1);

        // Basic sum
        vq = '{32'h0002_0000, 32'h0000_8000};
        send_vector(32'h0001_0000, 1'b0);
        expect_result("basic", 32'h0001_0000);
        chk("basic_abs", {32'd0, e_res}, 64'h0003_8000);

        // Single-beat negative vector
        vq = '{32'hFFFF_0000};
        send_vector(32'h0, 1'b0);
        expect_result("single", 32'h0);

        // Positive and negative saturation
        vq = '{32'h0002_0000, 32'h0001_0000};
        send_vector(32'h7FFF_0000, 1'b0);
        expect_result("sat_pos", 32'h7FFF_0000);
        vq = '{32'hFFFE_0000, 32'hFFFF_0000};
        send_vector(32'h8001_0000, 1'b0);
        expect_result("sat_neg", 32'h8001_0000);

        // Backpressure with a pending beat
        out_ready = 1'b0;
        vq = '{32'h0004_0000, 32'hFFFF_8000};
        send_vector(32'h0000_1000, 1'b0);
        expect_result("bp", 32'h0000_1000);
        held = out_result;
        b2 = 32'h0000_0100;
        p2 = 32'h0000_2000;
        in_valid = 1'b1; bias = b2; in_product = p2; in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_valid_hold", {63'd0, out_valid}, 64'd1);
            chk("bp_result_hold", {32'd0, out_result}, {32'd0, held});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", {63'd0, out_valid}, 64'd0);
        chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        vq = '{p2};
        expect_result("bp_next", b2);

        // Bubbles between beats
        vq = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_last = 1'b1;
            repeat (2) @(negedge clk);
            send_beat((i == 0) ? 32'h0 : 32'h1234_5678, vq[i], i == 2);
            in_valid = 1'b0;
        end
        in_last = 1'b0;
        expect_result("bubble", 32'h0);

        // Randomized vectors
        for (int v = 0; v < 12; v++) begin
            logic [DW-1:0] rb = rand_prod();
            vq.delete();
            for (int k = 0; k < $urandom_range(1, 8); k++) vq.push_back(rand_prod());
            send_vector(rb, 1'b1);
            expect_result($sformatf("rnd%0d", v), rb);
        end

        // Over-length vector
        vq.delete();
        for (int k = 0; k < 1030; k++) vq.push_back({{20{1'b0}}, 12'($urandom)});
        send_vector(32'h0000_0010, 1'b0);
        expect_result("overlen", 32'h0000_0010);

        // Asynchronous reset mid-vector
        send_beat(32'h0, 32'h0001_0000, 1'b0);
        send_beat(32'h0, 32'h0001_0000, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_result", {32'd0, out_result}, 64'd0);
        chk("arst_count", {54'd0, out_count}, 64'd0);
        chk("arst_sat", {63'd0, out_sat}, 64'd0);
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vq = '{32'h0000_4000};
        send_vector(32'h0, 1'b0);
        expect_result("post_rst", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
